// File: rtl/ttl_74165_sync.sv
//============================================================================
// ttl_74165_sync : synchronous 74LS165 parallel-load / serial-out register.
// Define TTL_74165_PAR_TAP_EN to expose all stages on Q_TAP.  Rev 1.0
//============================================================================
`default_nettype none

module ttl_74165_sync #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             RESETn,
  input  logic             Cen,
  input  logic             CLK_INH,
  input  logic             SH_LDn,
  input  logic             SER,
  input  logic [WIDTH-1:0] D,
`ifdef TTL_74165_PAR_TAP_EN
  output logic [WIDTH-1:0] Q_TAP,
`endif
  output logic             QH,
  output logic             QHn
);

  generate
    if (WIDTH < 2) begin : g_width_check
      $error("ttl_74165_sync: WIDTH must be at least 2");
    end
  endgenerate

  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_next;
  logic             gate;
  logic             last_gate;
  logic             gate_rise;

  // The chip ORs its clock and inhibit pins before the edge detector.
  assign gate      = Cen | CLK_INH;
  assign gate_rise = gate & ~last_gate;

  always_comb begin
    sr_next = sr;
    if (!SH_LDn) begin
      sr_next = D;
    end else if (gate_rise) begin
      sr_next = {sr[WIDTH-2:0], SER};
    end
  end

  // last_gate resets high so a gate already high at release is not an edge.
  always_ff @(posedge Clk) begin
    if (!RESETn) begin
      sr        <= '0;
      last_gate <= 1'b1;
    end else begin
      sr        <= sr_next;
      last_gate <= gate;
    end
  end

  assign QH  = sr[WIDTH-1];
  assign QHn = ~sr[WIDTH-1];

`ifdef TTL_74165_PAR_TAP_EN
  assign Q_TAP = sr;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ttl_74165_sync.sv
//============================================================================
// tb_ttl_74165_sync : self-checking bench, two chained instances.
// Rev 1.0
//============================================================================
`default_nettype none

module tb_ttl_74165_sync;

  localparam int WIDTH = 8;

  logic             Clk = 1'b0;
  logic             RESETn;
  logic             Cen;
  logic             CLK_INH;
  logic             SH_LDn;
  logic             ser;
  logic             cascade;
  logic [WIDTH-1:0] d_up;
  logic [WIDTH-1:0] d_dn;
  logic             qh_up, qhn_up;
  logic             qh_dn, qhn_dn;
  logic             ser_dn;
`ifdef TTL_74165_PAR_TAP_EN
  logic [WIDTH-1:0] tap_up, tap_dn;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  bit exp_q[$];

  always #5 Clk = ~Clk;

  // Downstream stage takes the upstream QH only in the cascade test.
  assign ser_dn = cascade ? qh_up : ser;

  ttl_74165_sync #(.WIDTH(WIDTH)) u_up (
    .Clk(Clk), .RESETn(RESETn), .Cen(Cen), .CLK_INH(CLK_INH),
    .SH_LDn(SH_LDn), .SER(ser), .D(d_up),
`ifdef TTL_74165_PAR_TAP_EN
    .Q_TAP(tap_up),
`endif
    .QH(qh_up), .QHn(qhn_up)
  );

  ttl_74165_sync #(.WIDTH(WIDTH)) u_dn (
    .Clk(Clk), .RESETn(RESETn), .Cen(Cen), .CLK_INH(CLK_INH),
    .SH_LDn(SH_LDn), .SER(ser_dn), .D(d_dn),
`ifdef TTL_74165_PAR_TAP_EN
    .Q_TAP(tap_dn),
`endif
    .QH(qh_dn), .QHn(qhn_dn)
  );

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // One chip clock pulse: Cen high for one Clk, then low for three.
  task automatic pulse();
    Cen = 1'b1;
    tick();
    Cen = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    bit e;
    RESETn = 1'b0; SH_LDn = 1'b0; d_dn = 8'hFF; d_up = 8'hFF;
    Cen = 1'b1; CLK_INH = 1'b0; ser = 1'b1; cascade = 1'b0;
    exp_q.push_back(1'b0);
    repeat (2) tick();
    e = exp_q.pop_front();
    n_checks++;
    if (qh_dn !== e || qhn_dn !== !e) begin
      n_fail++;
      $display("FAIL reset_out: QH=%b QHn=%b, required QH=%b QHn=%b", qh_dn, qhn_dn, e, !e);
    end
    // Release with Cen already high and SER=1: a false edge would plant a 1.
    RESETn = 1'b1; SH_LDn = 1'b1;
    repeat (2) tick();
    ser = 1'b0; Cen = 1'b0;
    tick();
    for (int k = 1; k <= 7; k++) begin
      exp_q.push_back(1'b0);
      pulse();
      e = exp_q.pop_front();
      n_checks++;
      if (qh_dn !== e || qhn_dn !== !e) begin
        n_fail++;
        $display("FAIL reset_no_edge pulse %0d: QH=%b, required %b", k, qh_dn, e);
      end
    end
  endtask

  task automatic test_load_shift();
    bit e;
    logic [7:0] pat;
    pat = 8'hA5;
    d_dn = pat; SH_LDn = 1'b0; ser = 1'b0; Cen = 1'b0;
    exp_q.push_back(pat[7]);
    tick();
    SH_LDn = 1'b1;
    e = exp_q.pop_front();
    n_checks++;
    if (qh_dn !== e || qhn_dn !== !e) begin
      n_fail++;
      $display("FAIL load_a5: QH=%b QHn=%b, required QH=%b", qh_dn, qhn_dn, e);
    end
    for (int k = 1; k <= 8; k++) begin
      exp_q.push_back(k < 8 ? pat[7-k] : 1'b0);
      pulse();
      e = exp_q.pop_front();
      n_checks++;
      if (qh_dn !== e || qhn_dn !== !e) begin
        n_fail++;
        $display("FAIL shift_a5 pulse %0d: QH=%b QHn=%b, required QH=%b", k, qh_dn, qhn_dn, e);
      end
    end
`ifdef TTL_74165_PAR_TAP_EN
    n_checks++;
    if (tap_dn !== 8'h00) begin
      n_fail++;
      $display("FAIL shift_a5_tap: Q_TAP=%h, required 00", tap_dn);
    end
`endif
  endtask

  task automatic test_serial_fill();
    bit e;
    ser = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      exp_q.push_back(k == 8);
      pulse();
      e = exp_q.pop_front();
      n_checks++;
      if (qh_dn !== e || qhn_dn !== !e) begin
        n_fail++;
        $display("FAIL serial_fill pulse %0d: QH=%b, required %b", k, qh_dn, e);
      end
    end
`ifdef TTL_74165_PAR_TAP_EN
    n_checks++;
    if (tap_dn !== 8'hFF) begin
      n_fail++;
      $display("FAIL serial_fill_tap: Q_TAP=%h, required ff", tap_dn);
    end
`endif
  endtask

  task automatic test_inhibit();
    bit e;
    Cen = 1'b1; d_dn = 8'h80; SH_LDn = 1'b0;
    tick();
    SH_LDn = 1'b1; CLK_INH = 1'b1;
    tick();
    Cen = 1'b0; ser = 1'b0;
    tick();
    exp_q.push_back(1'b1);
    e = exp_q.pop_front();
    n_checks++;
    if (qh_dn !== e) begin
      n_fail++;
      $display("FAIL inhibit_load: QH=%b, required %b", qh_dn, e);
    end
    for (int k = 1; k <= 5; k++) begin
      exp_q.push_back(1'b1);
      pulse();
      e = exp_q.pop_front();
      n_checks++;
      if (qh_dn !== e || qhn_dn !== !e) begin
        n_fail++;
        $display("FAIL inhibit_hold pulse %0d: QH=%b, required %b", k, qh_dn, e);
      end
    end
    Cen = 1'b1;
    tick();
    CLK_INH = 1'b0;
    tick();
    Cen = 1'b0;
    repeat (2) tick();
    exp_q.push_back(1'b1);
    e = exp_q.pop_front();
    n_checks++;
    if (qh_dn !== e) begin
      n_fail++;
      $display("FAIL inhibit_release: QH=%b, required %b", qh_dn, e);
    end
    exp_q.push_back(1'b0);
    pulse();
    e = exp_q.pop_front();
    n_checks++;
    if (qh_dn !== e || qhn_dn !== !e) begin
      n_fail++;
      $display("FAIL inhibit_after_pulse: QH=%b, required %b", qh_dn, e);
    end
  endtask

  task automatic test_load_priority();
    bit e;
    ser = 1'b0; SH_LDn = 1'b0; d_dn = 8'h80; Cen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      Cen = ~Cen;
      exp_q.push_back(1'b1);
      tick();
      e = exp_q.pop_front();
      n_checks++;
      if (qh_dn !== e) begin
        n_fail++;
        $display("FAIL load_prio_80 cycle %0d: QH=%b, required %b", i, qh_dn, e);
      end
    end
    d_dn = 8'h01;
    for (int i = 0; i < 10; i++) begin
      Cen = ~Cen;
      exp_q.push_back(1'b0);
      tick();
      e = exp_q.pop_front();
      n_checks++;
      if (qh_dn !== e) begin
        n_fail++;
        $display("FAIL load_prio_01 cycle %0d: QH=%b, required %b", i, qh_dn, e);
      end
    end
    // Gate rises during the final load cycle; that edge must not shift.
    Cen = 1'b1;
    tick();
    SH_LDn = 1'b1;
    tick();
    Cen = 1'b0;
    tick();
    for (int k = 1; k <= 7; k++) begin
      exp_q.push_back(k == 7);
      pulse();
      e = exp_q.pop_front();
      n_checks++;
      if (qh_dn !== e) begin
        n_fail++;
        $display("FAIL load_release pulse %0d: QH=%b, required %b", k, qh_dn, e);
      end
    end
  endtask

  task automatic test_reset_cascade();
    bit e;
    logic [15:0] words [2];
    words[0] = 16'h8001;
    words[1] = 16'hB25C;
    cascade = 1'b1; ser = 1'b0; Cen = 1'b0;
    d_dn = words[0][15:8]; d_up = words[0][7:0];
    SH_LDn = 1'b0;
    tick();
    SH_LDn = 1'b1;
    repeat (3) pulse();
`ifdef TTL_74165_PAR_TAP_EN
    n_checks++;
    if (tap_dn !== 8'h00 || tap_up !== 8'h08) begin
      n_fail++;
      $display("FAIL cascade_mid_taps: dn=%h up=%h, required dn=00 up=08", tap_dn, tap_up);
    end
`endif
    RESETn = 1'b0;
    exp_q.push_back(1'b0);
    tick();
    e = exp_q.pop_front();
    n_checks++;
    if (qh_dn !== e || qh_up !== e || qhn_dn !== !e || qhn_up !== !e) begin
      n_fail++;
      $display("FAIL mid_reset: QH dn=%b up=%b, required %b", qh_dn, qh_up, e);
    end
`ifdef TTL_74165_PAR_TAP_EN
    n_checks++;
    if (tap_dn !== 8'h00 || tap_up !== 8'h00) begin
      n_fail++;
      $display("FAIL mid_reset_taps: dn=%h up=%h, required 00 00", tap_dn, tap_up);
    end
`endif
    RESETn = 1'b1;
    tick();
    foreach (words[w]) begin
      d_dn = words[w][15:8]; d_up = words[w][7:0];
      SH_LDn = 1'b0;
      exp_q.push_back(words[w][15]);
      tick();
      SH_LDn = 1'b1;
      e = exp_q.pop_front();
      n_checks++;
      if (qh_dn !== e) begin
        n_fail++;
        $display("FAIL cascade %h bit 15: QH=%b, required %b", words[w], qh_dn, e);
      end
      for (int k = 1; k <= 16; k++) begin
        exp_q.push_back(k < 16 ? words[w][15-k] : 1'b0);
        pulse();
        e = exp_q.pop_front();
        n_checks++;
        if (qh_dn !== e || qhn_dn !== !e) begin
          n_fail++;
          $display("FAIL cascade %h pulse %0d: QH=%b, required %b", words[w], k, qh_dn, e);
        end
      end
    end
    cascade = 1'b0;
  endtask

  initial begin
    RESETn = 1'b0; Cen = 1'b0; CLK_INH = 1'b0; SH_LDn = 1'b1;
    ser = 1'b0; cascade = 1'b0; d_up = '0; d_dn = '0;
    test_reset();
    test_load_shift();
    test_serial_fill();
    test_inhibit();
    test_load_priority();
    test_reset_cascade();
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
